// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and helpers for the cache refill controller.
package cache_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INDEX_W = 7;
  localparam int unsigned TAG_W   = 9;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCheck,
    StMreq,
    StFill,
    StWrite,
    StDone
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// CPU, cache and backing-memory signal bundle for the refill controller.
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  // CPU side
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;

  // Cache array side
  logic              c_w_rd;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_hit;

  // Backing memory side
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Controller view
  modport master (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, c_rdata, c_hit, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_err, c_w_rd, c_addr, c_wdata,
    output mem_req, mem_wr, mem_addr, mem_wdata
  );

  // Environment view (CPU, cache array and memory together)
  modport slave (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata, c_rdata, c_hit, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_err, c_w_rd, c_addr, c_wdata,
    input  mem_req, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/req_timer.sv
// Memory-wait timeout counter: cleared outside the waiting states, counts while enabled.
module req_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_1,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count waiting cycles; holds once the limit is reached.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // Flags the last permitted waiting cycle, so the wait lasts exactly TIMEOUT_CYCLES.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: read lookup with miss refill, write-through with allocate,
// memory timeout and a saturating read-miss counter. All outputs are registered.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_1,
  input  logic                 rst,
  cache_refill_ctrl_if.master  bus,
  output logic [CNT_W-1:0]     miss_cnt
);

  state_e            state;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] fill_data;
  logic              timer_clear;
  logic              timer_en;
  logic              expired;

  // Timer only runs while waiting on memory; any other state holds it at zero.
  always_comb begin
    timer_en    = (state == StMreq) || (state == StWrite);
    timer_clear = !timer_en;
  end

  req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_req_timer (
    .clk_1  (clk_1),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  // Main FSM; every output is updated alongside the state that owns it.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state         <= StIdle;
      addr_lat      <= '0;
      fill_data     <= '0;
      miss_cnt      <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.c_w_rd    <= 1'b0;
      bus.c_addr    <= '0;
      bus.c_wdata   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.cpu_req) begin
            addr_lat   <= bus.cpu_addr;
            bus.c_addr <= bus.cpu_addr;
            if (bus.cpu_wr) begin
              // Allocate into the cache and start the write-through together.
              state         <= StWrite;
              bus.c_w_rd    <= 1'b1;
              bus.c_wdata   <= bus.cpu_wdata;
              bus.mem_req   <= 1'b1;
              bus.mem_wr    <= 1'b1;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
            end else begin
              state      <= StLookup;
              bus.c_w_rd <= 1'b0;
            end
          end
        end
        StLookup: begin
          state <= StCheck;
        end
        StCheck: begin
          if (bus.c_hit) begin
            bus.cpu_rdata <= bus.c_rdata;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b0;
            state         <= StDone;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_wr   <= 1'b0;
            bus.mem_addr <= addr_lat;
            miss_cnt     <= sat_inc(miss_cnt);
            state        <= StMreq;
          end
        end
        StMreq: begin
          // Ack wins over a timeout landing on the same cycle.
          if (bus.mem_ack) begin
            fill_data   <= bus.mem_rdata;
            bus.mem_req <= 1'b0;
            bus.c_w_rd  <= 1'b1;
            bus.c_addr  <= addr_lat;
            bus.c_wdata <= bus.mem_rdata;
            state       <= StFill;
          end else if (expired) begin
            bus.mem_req   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            state         <= StDone;
          end
        end
        StFill: begin
          bus.c_w_rd    <= 1'b0;
          bus.c_wdata   <= '0;
          bus.cpu_rdata <= fill_data;
          bus.cpu_ready <= 1'b1;
          bus.cpu_err   <= 1'b0;
          state         <= StDone;
        end
        StWrite: begin
          // Cache write strobe only lasts the first WRITE cycle.
          bus.c_w_rd  <= 1'b0;
          bus.c_wdata <= '0;
          if (bus.mem_ack || expired) begin
            bus.mem_req   <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= !bus.mem_ack;
            state         <= StDone;
          end
        end
        StDone: begin
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          state         <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl with behavioural cache array and memory.
module tb_cache_refill_ctrl;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic        clk_1 = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] miss_cnt;

  always #5 clk_1 = ~clk_1;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_1   (clk_1),
    .rst     (rst),
    .bus     (bus.master),
    .miss_cnt(miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  exp_t sb_q[$];
  exp_t mon_e;

  // Cache array model: combinational read, writes on c_w_rd or bench preload.
  bit [7:0]    cmem [0:65535];
  bit          cval [0:65535];
  bit          pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  assign bus.c_hit   = cval[bus.c_addr];
  assign bus.c_rdata = cmem[bus.c_addr];

  always @(posedge clk_1) begin
    if (pre_en) begin
      cmem[pre_addr] <= pre_data;
      cval[pre_addr] <= 1'b1;
    end
    if (bus.c_w_rd) begin
      cmem[bus.c_addr] <= bus.c_wdata;
      cval[bus.c_addr] <= 1'b1;
    end
  end

  // Memory model: acks once mem_req has been seen for more than ack_delay cycles.
  int          ack_delay = 0;
  logic [7:0]  mem_data = '0;
  logic        model_ack = 1'b0;
  logic        inject_ack = 1'b0;
  int          mem_cnt = 0;
  bit          ack_done = 1'b0;
  logic        ack_wr = 1'b0;
  logic [15:0] ack_addr = '0;
  logic [7:0]  ack_wdata = '0;
  int          memreq_cycles = 0;

  assign bus.mem_ack   = model_ack | inject_ack;
  assign bus.mem_rdata = mem_data;

  always @(negedge clk_1) begin
    model_ack = 1'b0;
    if (bus.mem_req) begin
      memreq_cycles++;
      if (!ack_done) begin
        mem_cnt++;
        if (ack_delay >= 0 && mem_cnt > ack_delay) begin
          model_ack = 1'b1;
          ack_done  = 1'b1;
          ack_wr    = bus.mem_wr;
          ack_addr  = bus.mem_addr;
          ack_wdata = bus.mem_wdata;
        end
      end
    end else begin
      mem_cnt  = 0;
      ack_done = 1'b0;
    end
  end

  // Output monitor: cache writes and completions, popping the scoreboard on cpu_ready.
  int          cwr_cycles = 0;
  int          ready_cnt = 0;
  logic [15:0] fill_addr = '0;
  logic [7:0]  fill_data = '0;

  always @(negedge clk_1) begin
    if (bus.c_w_rd) begin
      cwr_cycles++;
      fill_addr = bus.c_addr;
      fill_data = bus.c_wdata;
    end
    if (bus.cpu_ready) begin
      ready_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("cpu_rdata", bus.cpu_rdata, mon_e.rdata);
        check_eq("cpu_err", bus.cpu_err, mon_e.err);
      end
    end
  end

  // One CPU access; returns cycles from accept edge to the cpu_ready cycle.
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata, input bit exp_err, output int lat);
    int r0;
    @(negedge clk_1);
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    r0  = ready_cnt;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_1);
      #1;
      lat++;
      if (lat == 1) begin
        // Drop and scramble the request: the accepted access must carry on.
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = ~wr;
        bus.cpu_addr  = 16'hFFFF;
        bus.cpu_wdata = 8'hFF;
      end
      if (ready_cnt != r0) break;
    end
    if (ready_cnt == r0) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int mr0;
    int cw0;
    int r0;
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk_1);
    #1;
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_mem_wr", bus.mem_wr, 0);
    check_eq("rst_c_w_rd", bus.c_w_rd, 0);
    check_eq("rst_cpu_ready", bus.cpu_ready, 0);
    check_eq("rst_cpu_err", bus.cpu_err, 0);
    check_eq("rst_cpu_rdata", bus.cpu_rdata, 0);
    check_eq("rst_c_addr", bus.c_addr, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_c_wdata", bus.c_wdata, 0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b1;

    // Preload line 0x0004
    @(negedge clk_1);
    pre_en = 1'b1; pre_addr = 16'h0004; pre_data = 8'hA9;
    @(negedge clk_1);
    pre_en = 1'b0;

    // Read hit
    mr0 = memreq_cycles; cw0 = cwr_cycles;
    do_req(1'b0, 16'h0004, 8'h00, 8'hA9, 1'b0, lat);
    check_eq("hit_latency", lat, 3);
    check_eq("hit_no_mem_req", memreq_cycles - mr0, 0);
    check_eq("hit_no_c_w_rd", cwr_cycles - cw0, 0);
    check_eq("hit_miss_cnt", miss_cnt, 0);

    // Read miss, ack in the 6th MREQ cycle
    ack_delay = 5; mem_data = 8'h5C;
    mr0 = memreq_cycles; cw0 = cwr_cycles;
    do_req(1'b0, 16'h1234, 8'h00, 8'h5C, 1'b0, lat);
    check_eq("miss_latency", lat, 10);
    check_eq("miss_mem_req_cycles", memreq_cycles - mr0, 6);
    check_eq("miss_fill_cycles", cwr_cycles - cw0, 1);
    check_eq("miss_fill_addr", fill_addr, 16'h1234);
    check_eq("miss_fill_data", fill_data, 8'h5C);
    check_eq("miss_ack_wr", ack_wr, 0);
    check_eq("miss_ack_addr", ack_addr, 16'h1234);
    check_eq("miss_cnt_1", miss_cnt, 1);
    mr0 = memreq_cycles;
    do_req(1'b0, 16'h1234, 8'h00, 8'h5C, 1'b0, lat);
    check_eq("reread_latency", lat, 3);
    check_eq("reread_no_mem_req", memreq_cycles - mr0, 0);
    check_eq("reread_miss_cnt", miss_cnt, 1);

    // Write-through with allocate, ack in the 3rd WRITE cycle
    ack_delay = 2;
    mr0 = memreq_cycles; cw0 = cwr_cycles;
    do_req(1'b1, 16'h0080, 8'h3E, 8'h00, 1'b0, lat);
    check_eq("wr_latency", lat, 4);
    check_eq("wr_mem_req_cycles", memreq_cycles - mr0, 3);
    check_eq("wr_c_w_rd_cycles", cwr_cycles - cw0, 1);
    check_eq("wr_fill_addr", fill_addr, 16'h0080);
    check_eq("wr_fill_data", fill_data, 8'h3E);
    check_eq("wr_ack_wr", ack_wr, 1);
    check_eq("wr_ack_addr", ack_addr, 16'h0080);
    check_eq("wr_ack_wdata", ack_wdata, 8'h3E);
    check_eq("wr_miss_cnt", miss_cnt, 1);
    do_req(1'b0, 16'h0080, 8'h00, 8'h3E, 1'b0, lat);
    check_eq("wr_reread_latency", lat, 3);

    // Read miss with no ack: timeout after 8 cycles
    ack_delay = -1;
    mr0 = memreq_cycles; cw0 = cwr_cycles;
    do_req(1'b0, 16'h0BAD, 8'h00, 8'h00, 1'b1, lat);
    check_eq("to_latency", lat, 11);
    check_eq("to_mem_req_cycles", memreq_cycles - mr0, 8);
    check_eq("to_no_fill", cwr_cycles - cw0, 0);
    check_eq("to_miss_cnt", miss_cnt, 2);

    // Ack in the same cycle mem_req rises
    ack_delay = 0; mem_data = 8'h77;
    mr0 = memreq_cycles;
    do_req(1'b0, 16'h2222, 8'h00, 8'h77, 1'b0, lat);
    check_eq("ack0_latency", lat, 5);
    check_eq("ack0_mem_req_cycles", memreq_cycles - mr0, 1);
    check_eq("ack0_miss_cnt", miss_cnt, 3);

    // Write with no ack: timeout, cache strobe still issued once
    ack_delay = -1;
    mr0 = memreq_cycles; cw0 = cwr_cycles;
    do_req(1'b1, 16'h0300, 8'h42, 8'h00, 1'b1, lat);
    check_eq("wto_latency", lat, 9);
    check_eq("wto_mem_req_cycles", memreq_cycles - mr0, 8);
    check_eq("wto_c_w_rd_cycles", cwr_cycles - cw0, 1);

    // Reset during MREQ, then a late ack after release
    ack_delay = -1;
    @(negedge clk_1);
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h4444;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1);
      #1;
      bus.cpu_req = 1'b0;
      if (bus.mem_req) break;
    end
    check_eq("rr_reached_mreq", bus.mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rr_mem_req_async", bus.mem_req, 0);
    check_eq("rr_miss_cnt_async", miss_cnt, 0);
    check_eq("rr_cpu_ready_async", bus.cpu_ready, 0);
    r0 = ready_cnt; cw0 = cwr_cycles;
    repeat (2) @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    inject_ack = 1'b1; mem_data = 8'hEE;
    @(negedge clk_1);
    inject_ack = 1'b0;
    repeat (8) @(negedge clk_1);
    #1;
    check_eq("rr_no_ready", ready_cnt - r0, 0);
    check_eq("rr_no_c_w_rd", cwr_cycles - cw0, 0);
    check_eq("rr_mem_req_idle", bus.mem_req, 0);
    check_eq("rr_miss_cnt", miss_cnt, 0);

    // Controller is back in IDLE and serves a hit normally
    do_req(1'b0, 16'h0004, 8'h00, 8'hA9, 1'b0, lat);
    check_eq("post_rst_latency", lat, 3);
    check_eq("post_rst_miss_cnt", miss_cnt, 0);

    repeat (2) @(negedge clk_1);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 SHALL use one clock and an asynchronous active-low reset on ports named clk_1 and rst.
REQ-003 clk_1  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU access request, held until cpu_ready.
REQ-006 cpu_wr  in  1  1 = write, 0 = read; sampled at accept.
REQ-007 cpu_addr  in  16  access address; sampled at accept.
REQ-008 cpu_wdata  in  8  write data; sampled at accept.
REQ-009 cpu_rdata  out  8  read data; valid while cpu_ready=1.
REQ-010 cpu_ready  out  1  one-cycle completion pulse.
REQ-011 cpu_err  out  1  qualifies cpu_ready; 1 = memory timeout.
REQ-012 c_w_rd  out  1  cache w_rd strobe (1 = write).
REQ-013 c_addr  out  16  cache address.
REQ-014 c_wdata  out  8  cache write data; 8'h00 when c_w_rd=0.
REQ-015 c_rdata  in  8  cache read data.
REQ-016 c_hit  in  1  cache hit flag.
REQ-017 mem_req / mem_wr / mem_addr / mem_wdata  out  1/1/16/8  backing-memory request.
REQ-018 mem_rdata / mem_ack  in  8/1  memory read data and one-cycle acknowledge.
REQ-019 miss_cnt  out  16  saturating read-miss counter.

Function
REQ-020 FSM states SHALL be IDLE, LOOKUP, CHECK, MREQ, FILL, WRITE and DONE.
REQ-021 IDLE: on cpu_req=1, SHALL latch cpu_wr, cpu_addr and cpu_wdata, then go to LOOKUP if cpu_wr=0 or WRITE if cpu_wr=1.
REQ-022 LOOKUP SHALL drive c_addr = latched address with c_w_rd=0 for one cycle, then go to CHECK.
REQ-023 CHECK SHALL sample c_hit and c_rdata; on hit=1 it SHALL register the data and go to DONE, otherwise go to MREQ.
REQ-024 Read-hit latency SHALL be 3 cycles from the accept edge to the cpu_ready=1 cycle.
REQ-025 MREQ SHALL hold mem_req=1, mem_wr=0 and mem_addr = latched address until mem_ack=1; mem_rdata SHALL be captured on the mem_ack edge.
REQ-026 After mem_ack in MREQ the FSM SHALL go to FILL.
REQ-027 FILL SHALL drive c_w_rd=1, c_addr = latched address and c_wdata = captured data for exactly one cycle, then go to DONE with cpu_rdata = captured data.
REQ-028 Each read miss SHALL increment miss_cnt, saturating at 16'hFFFF.
REQ-029 WRITE SHALL use write-through with allocate.
REQ-030 In the first cycle of WRITE, c_w_rd SHALL be 1 and c_wdata = latched data.
REQ-031 WRITE SHALL hold mem_req=1, mem_wr=1 and mem_wdata = latched data until mem_ack=1, then go to DONE.
REQ-032 A timeout counter SHALL run in MREQ and WRITE and clear on state entry.
REQ-033 When the counter reaches TIMEOUT_CYCLES with no ack, the FSM SHALL go to DONE with cpu_err=1 and cpu_rdata=8'h00, and SHALL skip FILL.
REQ-034 DONE SHALL assert cpu_ready=1 for one cycle, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-035 mem_ack arriving in the same cycle mem_req rises SHALL be accepted; mem_ack in any other state SHALL be ignored.
REQ-036 c_hit and c_rdata SHALL be ignored outside CHECK.
REQ-037 cpu_req dropping after accept SHALL NOT abort the access.
REQ-038 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-039 rst=0 SHALL force the FSM to IDLE immediately.
REQ-040 While rst=0: mem_req=0, mem_wr=0, c_w_rd=0, cpu_ready=0, cpu_err=0, cpu_rdata=0, all addresses/data=0, miss_cnt=0, timer=0.
REQ-041 Reset mid-transaction SHALL abandon the access without a cpu_ready pulse; a late mem_ack after release SHALL be ignored.

Structure
REQ-042 A shared package cache_pkg SHALL hold the state encoding, ADDR_W=16, DATA_W=8, INDEX_W=7 and TAG_W=9.
REQ-043 The timeout counter SHALL be the sub-module req_timer, with clear/enable inputs and an expired output.

Verification
REQ-044 Preloaded line 0x0004=8'hA9, read 0x0004 -> one cache lookup, no mem_req, cpu_ready 3 cycles after accept with cpu_rdata=8'hA9.
REQ-045 Read 0x1234 miss, memory acks after 5 cycles with 8'h5C -> one FILL cycle with c_addr=16'h1234 and c_wdata=8'h5C, cpu_rdata=8'h5C, miss_cnt=1; re-read hits with 8'h5C.
REQ-046 Write 0x0080=8'h3E, ack after 2 cycles -> c_w_rd pulse plus mem_wr=1 with mem_wdata=8'h3E; cpu_err=0; a later read of 0x0080 hits with 8'h3E.
REQ-047 TIMEOUT_CYCLES=8, read miss and mem_ack never arrives -> mem_req drops after 8 cycles, cpu_ready=1 with cpu_err=1 and cpu_rdata=8'h00, no c_w_rd pulse.
REQ-048 rst pulsed low during MREQ, then mem_ack arrives after release -> mem_req=0 asynchronously, FSM IDLE, no cpu_ready, miss_cnt=0.
